// File: rtl/main_run_ctrl.sv
// Host-side run controller for the Bambu "main" accelerator.
// It loads an image into main's slave RAM, starts main, times the run and streams back a result window.
module main_run_ctrl #(
  parameter int                ADDR_W      = 14,
  parameter int                DATA_W      = 16,
  parameter int                CYC_W       = 32,
  parameter logic [CYC_W-1:0]  TIMEOUT_CYC = CYC_W'(200000000)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_load_len,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_rd_len,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        S_oe_ram,
  output logic [1:0]        S_we_ram,
  output logic [ADDR_W-1:0] S_addr_ram,
  output logic [DATA_W-1:0] S_Wdata_ram,
  output logic [7:0]        S_data_ram_size,
  output logic              start_port,
  input  logic              done_port,
  input  logic [DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]        Sout_DataRdy,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        status,
  output logic [CYC_W-1:0]  cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RDREQ, RDOUT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, load_len_q, rd_base_q, rd_len_q, idx_q;
  logic [7:0]        byte_q;
  logic              we_q;
  logic              oe_rd;
  logic              go_acc, rdy, timeout_hit;
  logic              unused_bits;

  assign go_acc      = (state_q == IDLE) && go;
  assign rdy         = Sout_DataRdy[0];
  assign timeout_hit = (cycles == TIMEOUT_CYC);
  assign unused_bits = ^{Sout_DataRdy[1], Sout_Rdata_ram[DATA_W-1:8]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    start_port = 1'b0;
    oe_rd      = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (go) state_d = (cfg_load_len != '0) ? LOAD : START;
      end
      LOAD: begin
        in_ready = !we_q;
        if (we_q && rdy && (idx_q == load_len_q - ADDR_W'(1))) state_d = START;
      end
      START: begin
        start_port = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        // A completion seen in the same cycle as the timeout still counts as a pass.
        if (done_port)        state_d = (rd_len_q != '0) ? RDREQ : DONE;
        else if (timeout_hit) state_d = DONE;
      end
      RDREQ: begin
        oe_rd = 1'b1;
        if (rdy) state_d = RDOUT;
      end
      RDOUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ((idx_q + ADDR_W'(1)) < rd_len_q) ? RDREQ : DONE;
      end
      DONE: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Run bookkeeping and the one outstanding write; cleared by reset so an access dies at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      idx_q    <= '0;
      cycles   <= '0;
      status   <= 2'd0;
      out_data <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          idx_q  <= '0;
          cycles <= '0;
          status <= 2'd0;
        end
        LOAD: begin
          if (!we_q && in_valid) begin
            we_q <= 1'b1;
          end else if (we_q && rdy) begin
            we_q  <= 1'b0;
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        START: cycles <= CYC_W'(1);
        RUN: begin
          if (done_port) begin
            status <= 2'd1;
            idx_q  <= '0;
          end else if (timeout_hit) begin
            status <= 2'd2;
          end else begin
            cycles <= cycles + CYC_W'(1);
          end
        end
        RDREQ: if (rdy) out_data <= Sout_Rdata_ram[7:0];
        RDOUT: if (out_ready) idx_q <= idx_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  // Configuration and the pending image byte carry no reset; they are only read while qualified.
  always_ff @(posedge clock) begin
    if (go_acc) begin
      base_q     <= cfg_base_addr;
      load_len_q <= cfg_load_len;
      rd_base_q  <= cfg_rd_base;
      rd_len_q   <= cfg_rd_len;
    end
    if ((state_q == LOAD) && in_valid && in_ready) byte_q <= in_data;
  end

  assign S_we_ram        = {1'b0, we_q};
  assign S_oe_ram        = {1'b0, oe_rd};
  assign S_addr_ram      = we_q  ? (base_q + idx_q) :
                           oe_rd ? (rd_base_q + idx_q) : '0;
  assign S_Wdata_ram     = we_q ? DATA_W'(byte_q) : '0;
  assign S_data_ram_size = (we_q || oe_rd) ? 8'd8 : 8'd0;

endmodule
